// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: 3-5 cycles per instruction, stalls in FETCH/MEM_RD/MEM_WR until mem_ready.
// Define MC_ILLEGAL_TRAP_EN to send unlisted opcodes to a locked TRAP state with an illegal_op output.
module mc_control_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t           state, next_state;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             timeout_q;
  logic             waiting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_nxt;
      if (state == S_DECODE) op_q <= opcode;
      if (wait_cnt_nxt == CNT_MAX) timeout_q <= 1'b1;
    end
  end

  // Only memory states stall; leaving one always happens with mem_ready=1, which clears the count.
  assign waiting = (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !mem_ready;

  always_comb begin
    wait_cnt_nxt = '0;
    if (waiting) wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    instr_done    = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // The async reset must not let a stray PC/IR load through while rst is held.
        pc_write  = mem_ready && !rst;
        ir_write  = mem_ready && !rst;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:            next_state = S_MEM_ADDR;
          OP_R:                    next_state = S_R_EXEC;
          OP_BEQ, OP_BNE:          next_state = S_BRANCH;
          OP_J:                    next_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = S_I_EXEC;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            next_state = S_TRAP;
`else
            next_state = S_FETCH;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b010;
        next_state = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = (op_q == OP_BNE) ? 3'b111 : 3'b001;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        instr_done    = 1'b1;
        next_state    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OP_ANDI: alu_op = 3'b011;
          OP_ORI:  alu_op = 3'b100;
          default: alu_op = 3'b000;
        endcase
        next_state = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_op = 1'b1;
        next_state = S_TRAP;
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

  assign mem_timeout = timeout_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: route-queue reference model compared every negedge, plus directed literal checks.
// Honours MC_ILLEGAL_TRAP_EN the same way as the design.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, mem_timeout;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;
  logic       ill;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic [3:0] state;
    logic       timeout;
    logic       illegal;
  } obs_t;

  obs_t dut_o;
  obs_t rec [20];
  int   n_chk = 0;
  int   n_err = 0;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
  assign ill = 1'b0;
`endif

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal_op(ill)
`endif
  );

  always #5 clk = ~clk;

  assign dut_o = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  instr_done, state_dbg, mem_timeout, ill};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_cur = 0;
  int         m_cnt = 0;
  bit         m_to  = 1'b0;
  logic [5:0] m_opq = '0;
  int         m_q[$];

  function automatic bit is_mem(input int s);
    return (s == 0 || s == 3 || s == 5);
  endfunction

  // The remaining state route an instruction takes after DECODE.
  task automatic push_route(input logic [5:0] op);
    case (op)
      6'd0:                m_q = '{6, 7};
      6'd2:                m_q = '{9};
      6'd4, 6'd5:          m_q = '{8};
      6'd8, 6'd12, 6'd13:  m_q = '{10, 11};
      6'd35:               m_q = '{2, 3, 4};
      6'd43:               m_q = '{2, 5};
      default:             m_q = {};
    endcase
  endtask

  function automatic obs_t exp_out(input int s, input logic [5:0] opq, input logic rdy, input logic r);
    obs_t o;
    o = '0;
    o.state = 4'(s);
    case (s)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.pc_write = rdy & ~r; o.ir_write = rdy & ~r; end
      1:  o.alu_src_b = 2'b11;
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 3'b010; end
      7:  begin o.reg_write = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = (opq == 6'd5) ? 3'b111 : 3'b001;
                o.pc_write_cond = 1; o.pc_src = 2'b01; end
      9:  begin o.pc_write = 1; o.pc_src = 2'b10; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10;
                o.alu_op = (opq == 6'd12) ? 3'b011 : (opq == 6'd13) ? 3'b100 : 3'b000; end
      11: o.reg_write = 1;
      12: o.illegal = 1;
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    obs_t e;
    int   nxt;
    if (rst) begin
      m_cur = 0; m_cnt = 0; m_to = 0; m_opq = '0; m_q = {};
      e = exp_out(0, '0, mem_ready, 1'b1);
    end else begin
      e = exp_out(m_cur, m_opq, mem_ready, 1'b0);
      e.timeout = m_to;
      if (m_cur == 12) nxt = 12;
      else if (m_cur == 1) begin
        m_opq = opcode;
        push_route(opcode);
        nxt = (m_q.size() != 0) ? m_q.pop_front() : (TRAP_ON ? 12 : 0);
      end
      else if (is_mem(m_cur) && !mem_ready) nxt = m_cur;
      else if (m_cur == 0) nxt = 1;
      else nxt = (m_q.size() != 0) ? m_q.pop_front() : 0;
      // An instruction is done in the cycle that hands control back to FETCH.
      e.instr_done = (m_cur != 0 && m_cur != 12 && nxt == 0);
      if (is_mem(m_cur) && !mem_ready) begin
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        if (m_cnt == 15) m_to = 1'b1;
      end else m_cnt = 0;
      m_cur = nxt;
    end
    chk("model_outputs", 32'(dut_o), 32'(e));
  end

  // ---------------- directed helpers ----------------
  task automatic run_instr(input logic [5:0] op, input int wstart, input int nwait, output int n);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      opcode    = op;
      mem_ready = (c >= wstart && c < wstart + nwait) ? 1'b0 : 1'b1;
      @(negedge clk);
      rec[c] = dut_o;
      @(posedge clk); #1;
      if (rec[c].instr_done) begin
        n = c + 1;
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int pool [10] = '{0, 2, 4, 5, 8, 12, 13, 35, 43, 63};

  initial begin
    int n;
    int pulses;
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_mem_read", 32'(mem_read), 1);
    chk("rst_done", 32'(instr_done), 0);
    tick();
    rst = 1'b0;

    run_instr(6'd0, 99, 0, n);
    chk("r_latency", 32'(n), 4);
    chk("r_fetch_pcw", 32'(rec[0].pc_write & rec[0].ir_write), 1);
    chk("r_states", {rec[0].state, rec[1].state, rec[2].state, rec[3].state}, 16'h0167);
    chk("r_aluop", 32'(rec[2].alu_op), 3'b010);
    chk("r_wb", {rec[3].reg_write, rec[3].reg_dst}, 2'b11);
    pulses = 0;
    for (int i = 0; i < 4; i++) pulses += int'(rec[i].instr_done);
    chk("r_pulses", 32'(pulses), 1);

    run_instr(6'd35, 3, 3, n);
    chk("lw_latency", 32'(n), 8);
    chk("lw_hold", {rec[3].state, rec[4].state, rec[5].state, rec[6].state}, 16'h3333);
    chk("lw_wb", {rec[7].state, 3'b000, rec[7].reg_write, rec[7].mem_to_reg}, 9'b0100_00011);

    run_instr(6'd5, 99, 0, n);
    chk("bne_latency", 32'(n), 3);
    chk("bne_ctl", {rec[2].alu_op, rec[2].pc_write_cond, rec[2].pc_src}, {3'b111, 1'b1, 2'b01});
    run_instr(6'd4, 99, 0, n);
    chk("beq_aluop", 32'(rec[2].alu_op), 3'b001);

    run_instr(6'd13, 99, 0, n);
    chk("ori_latency", 32'(n), 4);
    chk("ori_ctl", {rec[2].alu_op, rec[2].alu_src_b}, {3'b100, 2'b10});
    run_instr(6'd12, 99, 0, n);
    chk("andi_aluop", 32'(rec[2].alu_op), 3'b011);
    run_instr(6'd8, 99, 0, n);
    chk("addi_aluop", 32'(rec[2].alu_op), 3'b000);
    run_instr(6'd2, 99, 0, n);
    chk("j_ctl", {rec[2].pc_write, rec[2].pc_src, 4'(n)}, {1'b1, 2'b10, 4'd3});
    run_instr(6'd43, 99, 0, n);
    chk("sw_latency", 32'(n), 4);

    // Memory wait overrun in FETCH.
    opcode = 6'd0; mem_ready = 1'b0;
    repeat (14) tick();
    chk("to_before", 32'(mem_timeout), 0);
    tick();
    chk("to_set", 32'(mem_timeout), 1);
    chk("to_hold_fetch", 32'(state_dbg), 0);
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("to_sticky", 32'(mem_timeout), 1);
    rst = 1'b1; #1;
    chk("to_rst_clear", 32'(mem_timeout), 0);
    @(negedge clk); tick();
    rst = 1'b0;

    // Reset in the middle of a store wait.
    opcode = 6'd43; mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait_state", {state_dbg, 3'b000, mem_write}, {4'd5, 4'b0001});
    #2 rst = 1'b1; #1;
    chk("sw_rst_state", {state_dbg, 3'b000, mem_write}, 8'h00);
    @(negedge clk); tick();
    rst = 1'b0; mem_ready = 1'b1;

    // Unlisted opcode.
`ifdef MC_ILLEGAL_TRAP_EN
    opcode = 6'd63;
    repeat (3) tick();
    chk("trap_state", {state_dbg, 3'b000, ill, 3'b000, instr_done}, {4'd12, 4'b0001, 4'b0000});
    rst = 1'b1;
    @(negedge clk); tick();
    rst = 1'b0;
`else
    run_instr(6'd63, 99, 0, n);
    chk("nop_latency", 32'(n), 2);
    chk("nop_done_state", 32'(rec[1].state), 1);
    @(negedge clk);
    chk("nop_back_fetch", 32'(state_dbg), 0);
    tick();
`endif

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      opcode    = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63))
                                               : 6'(pool[$urandom_range(0, 9)]);
      mem_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0; mem_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main control unit for the MIPS core; sequences the shared ALU, register file, PC and unified memory over 3-5 cycles per instruction.
- Generates the 3-bit ALU operation code consumed by the ALU control decoder, plus all datapath mux/write enables.
- Stalls on a memory ready handshake; flags memory wait overruns.

Parameters:
- MEM_WAIT_MAX, 15, consecutive mem_ready-low cycles in a memory state before mem_timeout sets.
- CNT_W, 4, wait counter width; must hold MEM_WAIT_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load qualified externally by the ALU branch result.
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  output  1  0 PC, 1 ALUOut as memory address.
- mem_read, mem_write, ir_write  output  1 each.
- mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each.
- alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- alu_op  output  3  000 add, 001 beq, 010 R-type funct, 011 and, 100 or, 111 bne.
- instr_done  output  1  one-cycle pulse in an instruction's final cycle.
- mem_timeout  output  1  sticky memory-wait overrun flag.
- state_dbg  output  4  current state encoding.

Behaviour:
- Opcodes: R=0, j=2, beq=4, bne=5, addi=8, andi=12, ori=13, lw=35, sw=43.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12 (TRAP exists only with the macro).
- Outputs are Moore decodes of the state, except that pc_write and ir_write in FETCH are gated by mem_ready. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000. Holds while mem_ready=0. With mem_ready=1: pc_write=1, ir_write=1, go to DECODE.
- DECODE:
  - Drives alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Latches opcode into op_q.
  - Next state: lw/sw go to MEM_ADDR, R to R_EXEC, beq/bne to BRANCH, j to JUMP, addi/andi/ori to I_EXEC.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next state: lw goes to MEM_RD, sw goes to MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready. The completing cycle asserts instr_done and goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010, then R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001 (beq) or 111 (bne) selected from op_q, pc_write_cond=1, pc_src=01, instr_done=1, then FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op = 000 for addi, 011 for andi, 100 for ori, then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, then FETCH.
- Wait counter:
  - Increments each cycle in FETCH, MEM_RD or MEM_WR with mem_ready=0, saturating at MEM_WAIT_MAX.
  - Clears when mem_ready=1 or the state changes.
  - mem_timeout sets when the count reaches MEM_WAIT_MAX; the FSM keeps waiting. mem_timeout clears only on rst.
- Reset (async, any state, including mid memory wait): state=FETCH, op_q=0, counter=0, mem_timeout=0. instr_done=0. Outputs take FETCH values; pc_write and ir_write stay 0 while rst is high.
- mem_ready high in a non-memory state has no effect.
- Latency: lw 5 cycles, sw/R/addi/andi/ori 4 cycles, beq/bne/j 3 cycles (zero-wait memory).

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode in DECODE goes to TRAP. TRAP holds until rst, drives all enables 0, asserts an extra output illegal_op=1 and never pulses instr_done.
- Undefined: an unlisted opcode in DECODE goes straight to FETCH as a NOP (instr_done pulses in DECODE), and the illegal_op port is absent.

Test Plan:
- rst high, then low; mem_ready=1; opcode=0 -> state sequence 0,1,6,7,0. alu_op=010 in R_EXEC; reg_write=1, reg_dst=1 in R_WB; a single instr_done pulse.
- opcode=35 with mem_ready low for 3 cycles in MEM_RD -> state holds at 3 for those cycles; MEM_WB asserts reg_write=1, mem_to_reg=1; 5+3 cycles total.
- opcode=5 -> BRANCH drives alu_op=111, pc_write_cond=1, pc_src=01. opcode=4 -> alu_op=001.
- opcode=13 -> I_EXEC drives alu_op=100, alu_src_b=10. opcode=12 -> 011. opcode=8 -> 000.
- mem_ready held low in FETCH for 15 cycles -> mem_timeout=1 and stays 1 after mem_ready rises; rst clears it.
- rst asserted mid-MEM_WR -> state_dbg=0 immediately and mem_write=0. Opcode 63 with macro -> state 12, illegal_op=1; without macro -> returns to FETCH.
